// File: rtl/sloc_pkg.sv
// Shared defaults and FSM encoding for the sound-localisation correlator slice.
package sloc_pkg;

  localparam int W_DEF      = 11;
  localparam int N_DEF      = 20;
  localparam int MAXLAG_DEF = 8;
  localparam int ACCW_DEF   = 2*W_DEF + $clog2(N_DEF);
  localparam int LAGW_DEF   = $clog2(MAXLAG_DEF) + 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    CMP,
    DONE
  } state_e;

endpackage

// File: rtl/xcorr_bank.sv
// Ping-pong sample store: one bank fills from the ADC stream while the other is
// read by the correlator; a completed window swaps banks only when compute is idle.
module xcorr_bank
  import sloc_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int N    = N_DEF,
  parameter int IDXW = $clog2(N)
) (
  input  logic                clk_clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic signed [W-1:0] ch_a,
  input  logic signed [W-1:0] ch_b,
  input  logic                compute_idle,
  input  logic [IDXW-1:0]     rd_idx_a,
  input  logic [IDXW-1:0]     rd_idx_b,
  output logic signed [W-1:0] rd_a,
  output logic signed [W-1:0] rd_b,
  output logic                start,
  output logic                overrun
);

  localparam logic [IDXW-1:0] I_TOP = IDXW'(N - 1);

  logic signed [W-1:0] mem_a_q [2][N];
  logic signed [W-1:0] mem_a_d [2][N];
  logic signed [W-1:0] mem_b_q [2][N];
  logic signed [W-1:0] mem_b_d [2][N];
  logic [IDXW-1:0]     fill_idx_q, fill_idx_d;
  logic                fill_sel_q, fill_sel_d;
  logic                start_q, start_d;
  logic                overrun_q, overrun_d;

  // A completed window is dropped (index rewinds, bank kept) if compute is busy.
  always_comb begin
    mem_a_d    = mem_a_q;
    mem_b_d    = mem_b_q;
    fill_idx_d = fill_idx_q;
    fill_sel_d = fill_sel_q;
    start_d    = 1'b0;
    overrun_d  = 1'b0;
    if (sample_valid) begin
      mem_a_d[fill_sel_q][fill_idx_q] = ch_a;
      mem_b_d[fill_sel_q][fill_idx_q] = ch_b;
      if (fill_idx_q == I_TOP) begin
        fill_idx_d = '0;
        if (compute_idle) begin
          fill_sel_d = ~fill_sel_q;
          start_d    = 1'b1;
        end else begin
          overrun_d  = 1'b1;
        end
      end else begin
        fill_idx_d = fill_idx_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      fill_idx_q <= '0;
      fill_sel_q <= 1'b0;
      start_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      fill_idx_q <= fill_idx_d;
      fill_sel_q <= fill_sel_d;
      start_q    <= start_d;
      overrun_q  <= overrun_d;
    end
    mem_a_q <= mem_a_d;
    mem_b_q <= mem_b_d;
  end

  assign rd_a    = mem_a_q[~fill_sel_q][rd_idx_a];
  assign rd_b    = mem_b_q[~fill_sel_q][rd_idx_b];
  assign start   = start_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/tdoa_xcorr.sv
// TDOA cross-correlator: a single MAC sweeps lags -MAXLAG..+MAXLAG over the
// compute bank and reports the lag of peak correlation (earliest lag wins ties).
module tdoa_xcorr
  import sloc_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int N      = N_DEF,
  parameter int MAXLAG = MAXLAG_DEF,
  parameter int ACCW   = 2*W + $clog2(N),
  parameter int LAGW   = $clog2(MAXLAG) + 2
) (
  input  logic                   clk_clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic signed [W-1:0]    ch_a,
  input  logic signed [W-1:0]    ch_b,
  output logic                   busy,
  output logic                   result_valid,
  output logic signed [LAGW-1:0] best_lag,
  output logic signed [ACCW-1:0] best_corr,
  output logic                   overrun
);

  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0]        I_TOP = IDXW'(N - 1);
  localparam logic signed [LAGW-1:0] K_MIN = LAGW'(-MAXLAG);
  localparam logic signed [LAGW-1:0] K_MAX = LAGW'(MAXLAG);

  state_e                 state_q, state_d;
  logic signed [LAGW-1:0] k_q, k_d;
  logic [IDXW-1:0]        i_q, i_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] peak_q, peak_d;
  logic signed [LAGW-1:0] peak_lag_q, peak_lag_d;
  logic                   busy_q, busy_d;
  logic                   result_valid_q, result_valid_d;
  logic signed [LAGW-1:0] best_lag_q, best_lag_d;
  logic signed [ACCW-1:0] best_corr_q, best_corr_d;

  logic [IDXW-1:0]        rd_idx_b;
  logic signed [W-1:0]    rd_a, rd_b;
  logic signed [2*W-1:0]  prod;
  logic                   bank_start, bank_idle;
  logic [IDXW-1:0]        i_last;
  logic signed [LAGW-1:0] k_next;
  logic                   take_peak;

  xcorr_bank #(.W(W), .N(N), .IDXW(IDXW)) u_bank (
    .clk_clk      (clk_clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .ch_a         (ch_a),
    .ch_b         (ch_b),
    .compute_idle (bank_idle),
    .rd_idx_a     (i_q),
    .rd_idx_b     (rd_idx_b),
    .rd_a         (rd_a),
    .rd_b         (rd_b),
    .start        (bank_start),
    .overrun      (overrun)
  );

  // i+k is always inside the window, so modular index arithmetic is exact.
  assign rd_idx_b  = i_q + IDXW'(k_q);
  assign prod      = (2*W)'(rd_a) * (2*W)'(rd_b);
  assign bank_idle = (state_q == IDLE) && !bank_start;
  assign i_last    = k_q[LAGW-1] ? I_TOP : I_TOP - IDXW'(k_q);
  assign k_next    = k_q + LAGW'(1);
  assign take_peak = (k_q == K_MIN) || (acc_q > peak_q);

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    i_d            = i_q;
    acc_d          = acc_q;
    peak_d         = peak_q;
    peak_lag_d     = peak_lag_q;
    busy_d         = busy_q;
    result_valid_d = 1'b0;
    best_lag_d     = best_lag_q;
    best_corr_d    = best_corr_q;
    case (state_q)
      IDLE: begin
        if (bank_start) begin
          state_d = MAC;
          k_d     = K_MIN;
          i_d     = IDXW'(MAXLAG);
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      MAC: begin
        acc_d = acc_q + ACCW'(prod);
        if (i_q == i_last) begin
          state_d = CMP;
        end else begin
          i_d = i_q + IDXW'(1);
        end
      end
      CMP: begin
        if (take_peak) begin
          peak_d     = acc_q;
          peak_lag_d = k_q;
        end
        if (k_q == K_MAX) begin
          state_d        = DONE;
          busy_d         = 1'b0;
          result_valid_d = 1'b1;
          best_corr_d    = take_peak ? acc_q : peak_q;
          best_lag_d     = take_peak ? k_q : peak_lag_q;
        end else begin
          state_d = MAC;
          k_d     = k_next;
          i_d     = k_next[LAGW-1] ? IDXW'(-k_next) : '0;
          acc_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      k_q            <= '0;
      i_q            <= '0;
      acc_q          <= '0;
      peak_q         <= '0;
      peak_lag_q     <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      best_lag_q     <= '0;
      best_corr_q    <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      i_q            <= i_d;
      acc_q          <= acc_d;
      peak_q         <= peak_d;
      peak_lag_q     <= peak_lag_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      best_lag_q     <= best_lag_d;
      best_corr_q    <= best_corr_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign best_lag     = best_lag_q;
  assign best_corr    = best_corr_q;

endmodule

// File: tb/tb_tdoa_xcorr.sv
// Bench for tdoa_xcorr: directed and random windows checked against a
// plain-arithmetic cross-correlation model, plus overrun and reset scenarios.
module tb_tdoa_xcorr;
  import sloc_pkg::*;

  localparam int W       = W_DEF;
  localparam int N       = N_DEF;
  localparam int MAXLAG  = MAXLAG_DEF;
  localparam int ACCW    = 2*W + $clog2(N);
  localparam int LAGW    = $clog2(MAXLAG) + 2;
  localparam int TIMEOUT = 2000;

  logic                   clk_clk = 1'b0;
  logic                   reset;
  logic                   sample_valid;
  logic signed [W-1:0]    ch_a;
  logic signed [W-1:0]    ch_b;
  logic                   busy;
  logic                   result_valid;
  logic signed [LAGW-1:0] best_lag;
  logic signed [ACCW-1:0] best_corr;
  logic                   overrun;

  int checks   = 0;
  int errors   = 0;
  int rv_count = 0;
  int ov_count = 0;
  int win_a [N];
  int win_b [N];

  tdoa_xcorr #(.W(W), .N(N), .MAXLAG(MAXLAG), .ACCW(ACCW), .LAGW(LAGW)) dut (
    .clk_clk      (clk_clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .ch_a         (ch_a),
    .ch_b         (ch_b),
    .busy         (busy),
    .result_valid (result_valid),
    .best_lag     (best_lag),
    .best_corr    (best_corr),
    .overrun      (overrun)
  );

  always #5 clk_clk = ~clk_clk;

  always @(negedge clk_clk) begin
    if (result_valid === 1'b1) rv_count++;
    if (overrun === 1'b1) ov_count++;
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Reference: C(k) = sum a[i]*b[i+k], first strictly-greater peak wins.
  function automatic void refXcorr(output int lag, output longint corr);
    longint c;
    lag  = 0;
    corr = 0;
    for (int k = -MAXLAG; k <= MAXLAG; k++) begin
      c = 0;
      for (int i = 0; i < N; i++)
        if (i + k >= 0 && i + k < N) c += longint'(win_a[i]) * longint'(win_b[i + k]);
      if (k == -MAXLAG || c > corr) begin
        corr = c;
        lag  = k;
      end
    end
  endfunction

  function automatic int expLatency();
    int s = 0;
    for (int k = -MAXLAG; k <= MAXLAG; k++) s += N - ((k < 0) ? -k : k) + 1;
    return 1 + s;
  endfunction

  function automatic int randSample();
    return int'($urandom_range(2047)) - 1024;
  endfunction

  task automatic fillConst(input int va, input int vb);
    for (int i = 0; i < N; i++) begin
      win_a[i] = va;
      win_b[i] = vb;
    end
  endtask

  task automatic fillRandom(input bit shifted, input int shift);
    for (int i = 0; i < N; i++) win_a[i] = randSample();
    for (int i = 0; i < N; i++)
      win_b[i] = (shifted && i - shift >= 0 && i - shift < N) ? win_a[i - shift] : randSample();
  endtask

  task automatic applyStimulus(input int period);
    for (int i = 0; i < N; i++) begin
      ch_a         = W'(win_a[i]);
      ch_b         = W'(win_b[i]);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      if (i != N - 1) repeat (period - 1) tick();
    end
  endtask

  task automatic waitResult(output int cyc);
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < TIMEOUT) begin
      tick();
      cyc++;
    end
    checkOutput("result_seen", result_valid, 1);
  endtask

  task automatic checkWindow(input string tag, input int period, input bit check_lat);
    int exp_lag;
    longint exp_corr;
    int cyc;
    int rv0;
    refXcorr(exp_lag, exp_corr);
    rv0 = rv_count;
    applyStimulus(period);
    tick();
    checkOutput({tag, "_busy_rise"}, busy, 1);
    waitResult(cyc);
    cyc++;
    if (check_lat) checkOutput({tag, "_latency"}, cyc, expLatency());
    checkOutput({tag, "_lag"}, best_lag, exp_lag);
    checkOutput({tag, "_corr"}, best_corr, exp_corr);
    checkOutput({tag, "_busy_fall"}, busy, 0);
    tick();
    checkOutput({tag, "_rv_pulse"}, result_valid, 0);
    checkOutput({tag, "_lag_hold"}, best_lag, exp_lag);
    checkOutput({tag, "_rv_count"}, rv_count - rv0, 1);
  endtask

  initial begin
    int lag_a;
    longint corr_a;
    int cyc;
    int rv0;
    int ov0;

    reset        = 1'b1;
    sample_valid = 1'b0;
    ch_a         = '0;
    ch_b         = '0;
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rv", result_valid, 0);
    checkOutput("rst_lag", best_lag, 0);
    checkOutput("rst_corr", best_corr, 0);
    checkOutput("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick();

    fillConst(0, 0);
    win_a[10] = 100;
    win_b[10] = 100;
    checkWindow("imp_aligned", 50, 1'b1);

    fillConst(0, 0);
    win_a[5] = 100;
    win_b[8] = 100;
    checkWindow("imp_plus3", 50, 1'b0);

    fillConst(0, 0);
    win_a[8] = 100;
    win_b[5] = 100;
    checkWindow("imp_minus3", 50, 1'b0);

    fillConst(-1024, -1024);
    checkWindow("full_scale", 50, 1'b0);

    fillConst(0, 0);
    checkWindow("all_zero", 50, 1'b0);

    fillRandom(1'b0, 0);
    checkWindow("rand_plain", 7, 1'b0);
    fillRandom(1'b1, int'($urandom_range(10)) - 5);
    checkWindow("rand_shift", 3, 1'b0);
    fillRandom(1'b1, 6);
    checkWindow("rand_shift6", 1, 1'b0);

    // Second window lands while the first is still being correlated.
    ov0 = ov_count;
    rv0 = rv_count;
    fillRandom(1'b1, 2);
    refXcorr(lag_a, corr_a);
    applyStimulus(10);
    checkOutput("ovr_first_none", overrun, 0);
    fillRandom(1'b0, 0);
    applyStimulus(10);
    checkOutput("ovr_pulse", overrun, 1);
    checkOutput("ovr_busy", busy, 1);
    waitResult(cyc);
    checkOutput("ovr_lag", best_lag, lag_a);
    checkOutput("ovr_corr", best_corr, corr_a);
    tick();
    checkOutput("ovr_rv_count", rv_count - rv0, 1);
    checkOutput("ovr_count", ov_count - ov0, 1);
    fillRandom(1'b1, 3);
    checkWindow("after_ovr", 50, 1'b0);

    fillRandom(1'b1, -4);
    applyStimulus(5);
    repeat (99) tick();
    checkOutput("pre_rst_busy", busy, 1);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rv", result_valid, 0);
    checkOutput("midrst_lag", best_lag, 0);
    checkOutput("midrst_corr", best_corr, 0);
    checkOutput("midrst_ovr", overrun, 0);
    rv0 = rv_count;
    repeat (300) tick();
    checkOutput("midrst_no_result", rv_count - rv0, 0);
    checkOutput("midrst_idle", busy, 0);
    fillRandom(1'b1, 1);
    checkWindow("post_rst", 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
